// File: rtl/i2s_play_buffer.sv
// Ping-pong sample buffer feeding the I2S playback serializer; banks swap on read-address wrap.
// Latency: word_data is 1 clk after addr; writes land in the fill bank on the handshake cycle.
// Backpressure: wr_ready drops once the fill bank holds DEPTH samples, until the next swap.
// Optional build macro PLAY_BUF_MUTE_ON_UNDERRUN_EN: zero the output during an underrun frame.
module i2s_play_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] word_data,
    output logic              bank_sel,
    output logic              frame_done,
    output logic              underrun,
    input  logic              underrun_clr
);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } wr_state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Both banks in one array; the bank bit is the MSB of the index.
    logic [DATA_W-1:0] mem [2*DEPTH];

    wr_state_t         state;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              primed;
    logic              wr_hs;
    logic              wrap;
    logic              swap;

`ifdef PLAY_BUF_MUTE_ON_UNDERRUN_EN
    logic              mute;
`endif

    assign wr_hs = wr_valid & wr_ready;
    // Only a clean DEPTH-1 -> 0 step counts as a frame boundary.
    assign wrap  = (addr_q == LAST_ADDR) && (addr == '0);
    // Swap decision uses the registered state, so a write completing the bank on
    // the wrap cycle itself is too late and becomes an underrun.
    assign swap  = wrap && (state == FULL);

    // Fill-bank write port (storage is intentionally not reset)
    always_ff @(posedge clk) begin
        if (wr_hs) begin
            mem[{~bank_sel, wr_cnt}] <= wr_data;
        end
    end

    // Write FSM: accept DEPTH samples, then hold off the producer until the banks swap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FILL;
            wr_ready <= 1'b1;
            wr_cnt   <= '0;
        end else if (swap) begin
            state    <= FILL;
            wr_ready <= 1'b1;
            wr_cnt   <= '0;
        end else if (wr_hs) begin
            wr_cnt <= wr_cnt + ADDR_W'(1);
            if (wr_cnt == LAST_ADDR) begin
                state    <= FULL;
                wr_ready <= 1'b0;
            end
        end
    end

    // Frame boundary tracking: bank swap, frame pulse and sticky underrun (set beats clear)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q     <= '0;
            bank_sel   <= 1'b0;
            primed     <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            addr_q     <= addr;
            frame_done <= wrap;
            if (swap) begin
                bank_sel <= ~bank_sel;
                primed   <= 1'b1;
            end
            if (wrap && !swap) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

`ifdef PLAY_BUF_MUTE_ON_UNDERRUN_EN
    // Mute from an underrun boundary until the next successful swap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mute <= 1'b0;
        end else if (swap) begin
            mute <= 1'b0;
        end else if (wrap) begin
            mute <= 1'b1;
        end
    end
`endif

    // Registered read of the play bank; uses pre-swap bank_sel on a swap cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_data <= '0;
`ifdef PLAY_BUF_MUTE_ON_UNDERRUN_EN
        end else if (!primed || mute) begin
`else
        end else if (!primed) begin
`endif
            word_data <= '0;
        end else begin
            word_data <= mem[{bank_sel, addr}];
        end
    end

endmodule

// File: tb/tb_i2s_play_buffer.sv
// Self-checking bench for i2s_play_buffer against a queue-based playback model.
// Runs fixed scenarios from the block's intended use plus randomized frames.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_i2s_play_buffer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  addr;
    logic [15:0] word_data;
    logic        bank_sel;
    logic        frame_done;
    logic        underrun;
    logic        underrun_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    i2s_play_buffer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .addr         (addr),
        .word_data    (word_data),
        .bank_sel     (bank_sel),
        .frame_done   (frame_done),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    // Reference model: pending samples queue for the fill bank, a copy of the play frame
    logic [15:0] m_fill[$];
    logic [15:0] m_play[32];
    bit          m_primed;
    bit          m_mute;
    bit          m_underrun;
    bit          m_bank;
    bit          m_frame;
    logic [4:0]  m_addr_q;
    logic [15:0] m_word;

`ifdef PLAY_BUF_MUTE_ON_UNDERRUN_EN
    localparam bit MUTE_BUILD = 1'b1;
`else
    localparam bit MUTE_BUILD = 1'b0;
`endif

    task automatic model_reset();
        m_fill.delete();
        m_primed   = 0;
        m_mute     = 0;
        m_underrun = 0;
        m_bank     = 0;
        m_frame    = 0;
        m_addr_q   = 5'd0;
        m_word     = 16'h0;
    endtask

    task automatic do_reset();
        wr_valid     = 1'b0;
        wr_data      = 16'h0;
        addr         = 5'd0;
        underrun_clr = 1'b0;
        reset_n      = 1'b0;
        model_reset();
        #3;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: drive inputs, advance the model by the playback rules, then let the edge pass
    task automatic cyc(input bit v, input logic [15:0] d, input logic [4:0] a, input bit clr);
        bit full;
        bit wr;
        wr_valid     = v;
        wr_data      = d;
        addr         = a;
        underrun_clr = clr;
        full    = (m_fill.size() == 32);
        wr      = v && !full;
        m_frame = (m_addr_q == 5'd31) && (a == 5'd0);
        m_word  = (m_primed && !m_mute) ? m_play[a] : 16'h0;
        if (clr) m_underrun = 0;
        if (m_frame) begin
            if (full) begin
                foreach (m_play[k]) m_play[k] = m_fill[k];
                m_fill.delete();
                m_primed = 1;
                m_mute   = 0;
                m_bank   = ~m_bank;
            end else begin
                m_underrun = 1;
                if (MUTE_BUILD) m_mute = 1;
            end
        end
        if (wr) m_fill.push_back(d);
        m_addr_q = a;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b want=1", wr_ready); end
        total++; if (word_data !== 16'h0) begin bad++; $display("FAIL reset_word_data got=%h want=0000", word_data); end
        total++; if (bank_sel !== 1'b0) begin bad++; $display("FAIL reset_bank_sel got=%b want=0", bank_sel); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b want=0", underrun); end
    endtask

    task automatic test_empty_underrun();
        for (int i = 0; i < 32; i++) begin
            cyc(1'b0, 16'h0, 5'(i), 1'b0);
            total++; if (word_data !== 16'h0) begin bad++; $display("FAIL empty_word_data addr=%0d got=%h want=0000", i, word_data); end
            total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL empty_no_frame addr=%0d got=%b want=0", i, frame_done); end
        end
        cyc(1'b0, 16'h0, 5'd0, 1'b0);
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL empty_frame_done got=%b want=1", frame_done); end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL empty_underrun got=%b want=1", underrun); end
        total++; if (bank_sel !== 1'b0) begin bad++; $display("FAIL empty_bank_sel got=%b want=0", bank_sel); end
        cyc(1'b0, 16'h0, 5'd0, 1'b1);
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL empty_clr got=%b want=0", underrun); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL empty_pulse_width got=%b want=0", frame_done); end
    endtask

    task automatic test_first_fill();
        for (int i = 0; i < 32; i++) begin
            total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL fill1_ready idx=%0d got=%b want=1", i, wr_ready); end
            cyc(1'b1, 16'h0100 + 16'(i), 5'd0, 1'b0);
        end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL fill1_full got=%b want=0", wr_ready); end
        cyc(1'b1, 16'hDEAD, 5'd0, 1'b0);
        for (int i = 1; i < 32; i++) cyc(1'b0, 16'h0, 5'(i), 1'b0);
        cyc(1'b0, 16'h0, 5'd0, 1'b0);
        total++; if (bank_sel !== 1'b1) begin bad++; $display("FAIL fill1_swap_bank got=%b want=1", bank_sel); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL fill1_swap_ready got=%b want=1", wr_ready); end
        total++; if (word_data !== 16'h0) begin bad++; $display("FAIL fill1_swap_cycle_read got=%h want=0000", word_data); end
        for (int i = 1; i < 32; i++) begin
            cyc(1'b0, 16'h0, 5'(i), 1'b0);
            total++; if (word_data !== 16'h0100 + 16'(i)) begin bad++; $display("FAIL fill1_play addr=%0d got=%h want=%h", i, word_data, 16'h0100 + 16'(i)); end
        end
    endtask

    task automatic test_fill_while_play();
        cyc(1'b1, 16'h0200, 5'd31, 1'b0);
        total++; if (word_data !== 16'h011F) begin bad++; $display("FAIL fwp_hold got=%h want=011f", word_data); end
        for (int i = 1; i < 32; i++) begin
            cyc(1'b1, 16'h0200 + 16'(i), 5'(i), 1'b0);
            total++; if (word_data !== 16'h0100 + 16'(i)) begin bad++; $display("FAIL fwp_play addr=%0d got=%h want=%h", i, word_data, 16'h0100 + 16'(i)); end
        end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL fwp_full got=%b want=0", wr_ready); end
        cyc(1'b0, 16'h0, 5'd0, 1'b0);
        total++; if (bank_sel !== 1'b0) begin bad++; $display("FAIL fwp_swap_bank got=%b want=0", bank_sel); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL fwp_underrun got=%b want=0", underrun); end
        total++; if (word_data !== 16'h0100) begin bad++; $display("FAIL fwp_preswap_read got=%h want=0100", word_data); end
        for (int i = 1; i < 32; i++) begin
            cyc(1'b0, 16'h0, 5'(i), 1'b0);
            total++; if (word_data !== 16'h0200 + 16'(i)) begin bad++; $display("FAIL fwp_newbank addr=%0d got=%h want=%h", i, word_data, 16'h0200 + 16'(i)); end
        end
    endtask

    task automatic test_underrun_replay();
        logic [15:0] exp;
        cyc(1'b0, 16'h0, 5'd0, 1'b0);
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL rep_underrun got=%b want=1", underrun); end
        total++; if (bank_sel !== 1'b0) begin bad++; $display("FAIL rep_no_swap got=%b want=0", bank_sel); end
        total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL rep_frame_done got=%b want=1", frame_done); end
        for (int i = 1; i < 32; i++) begin
            cyc(1'b0, 16'h0, 5'(i), 1'b0);
            exp = MUTE_BUILD ? 16'h0 : 16'h0200 + 16'(i);
            total++; if (word_data !== exp) begin bad++; $display("FAIL rep_data addr=%0d got=%h want=%h", i, word_data, exp); end
        end
    endtask

    task automatic test_coincident();
        cyc(1'b1, 16'($urandom), 5'd31, 1'b1);
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL coin_clr got=%b want=0", underrun); end
        for (int i = 1; i < 31; i++) cyc(1'b1, 16'($urandom), 5'd31, 1'b0);
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL coin_ready31 got=%b want=1", wr_ready); end
        cyc(1'b1, 16'($urandom), 5'd0, 1'b0);
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL coin_underrun got=%b want=1", underrun); end
        total++; if (bank_sel !== 1'b0) begin bad++; $display("FAIL coin_no_swap got=%b want=0", bank_sel); end
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL coin_full got=%b want=0", wr_ready); end
        for (int i = 1; i < 32; i++) begin
            cyc(1'b0, 16'h0, 5'(i), 1'b0);
            total++; if (word_data !== m_word) begin bad++; $display("FAIL coin_replay addr=%0d got=%h want=%h", i, word_data, m_word); end
        end
        cyc(1'b0, 16'h0, 5'd0, 1'b0);
        total++; if (bank_sel !== 1'b1) begin bad++; $display("FAIL coin_late_swap got=%b want=1", bank_sel); end
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL coin_late_ready got=%b want=1", wr_ready); end
        for (int i = 1; i < 32; i++) begin
            cyc(1'b0, 16'h0, 5'(i), i == 10);
            total++; if (word_data !== m_word) begin bad++; $display("FAIL coin_play addr=%0d got=%h want=%h", i, word_data, m_word); end
        end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL coin_clr2 got=%b want=0", underrun); end
        cyc(1'b0, 16'h0, 5'd0, 1'b1);
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL coin_set_wins got=%b want=1", underrun); end
    endtask

    task automatic test_reset_midfill();
        for (int i = 0; i < 17; i++) cyc(1'b1, 16'($urandom), 5'd0, 1'b0);
        do_reset();
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", wr_ready); end
        total++; if (word_data !== 16'h0) begin bad++; $display("FAIL rmid_word got=%h want=0000", word_data); end
        total++; if (bank_sel !== 1'b0) begin bad++; $display("FAIL rmid_bank got=%b want=0", bank_sel); end
        for (int i = 0; i < 31; i++) cyc(1'b1, 16'($urandom), 5'd0, 1'b0);
        total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready31 got=%b want=1", wr_ready); end
        cyc(1'b1, 16'($urandom), 5'd0, 1'b0);
        total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL rmid_full got=%b want=0", wr_ready); end
        for (int i = 1; i < 32; i++) cyc(1'b0, 16'h0, 5'(i), 1'b0);
        cyc(1'b0, 16'h0, 5'd0, 1'b0);
        total++; if (bank_sel !== 1'b1) begin bad++; $display("FAIL rmid_swap got=%b want=1", bank_sel); end
        for (int i = 1; i < 32; i++) begin
            cyc(1'b0, 16'h0, 5'(i), 1'b0);
            total++; if (word_data !== m_word) begin bad++; $display("FAIL rmid_play addr=%0d got=%h want=%h", i, word_data, m_word); end
        end
    endtask

    task automatic test_random();
        bit v;
        bit clr;
        int reps;
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 32; i++) begin
                reps = $urandom_range(1, 2);
                for (int r = 0; r < reps; r++) begin
                    v   = ($urandom_range(0, 3) != 0);
                    clr = ($urandom_range(0, 15) == 0);
                    cyc(v, 16'($urandom), 5'(i), clr);
                    total++; if (word_data !== m_word) begin bad++; $display("FAIL rnd_word f=%0d a=%0d got=%h want=%h", f, i, word_data, m_word); end
                    total++; if (wr_ready !== (m_fill.size() < 32)) begin bad++; $display("FAIL rnd_ready f=%0d a=%0d got=%b want=%b", f, i, wr_ready, m_fill.size() < 32); end
                    total++; if (bank_sel !== m_bank) begin bad++; $display("FAIL rnd_bank f=%0d a=%0d got=%b want=%b", f, i, bank_sel, m_bank); end
                    total++; if (underrun !== m_underrun) begin bad++; $display("FAIL rnd_underrun f=%0d a=%0d got=%b want=%b", f, i, underrun, m_underrun); end
                    total++; if (frame_done !== m_frame) begin bad++; $display("FAIL rnd_frame f=%0d a=%0d got=%b want=%b", f, i, frame_done, m_frame); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty_underrun();
        test_first_fill();
        test_fill_while_play();
        test_underrun_replay();
        test_coincident();
        test_reset_midfill();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
